// File: rtl/vecsum_ctrl.sv
// vecsum_ctrl: sums a vector delivered as Chunks beats of Elements signed
// operands. Each accepted beat goes straight to an external pipelined adder
// tree with a fixed Latency. The tree's per-beat sums are accumulated as they
// come back. A tag shift register marks which tree_out cycles carry real sums.
//
// Optional feature: define VECSUM_SAT_EN so that every accumulation clamps to
// the signed NBitsOut range, and out_sat reports whether any clamp happened
// in the current vector. Without it, accumulation wraps and out_sat is 0.
//
// dbg_state encoding: 0 IDLE, 1 FEED, 2 DRAIN, 3 HOLD.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A source holds valid and its data stable until that transfer happens.
// in_ready depends only on state and reset, never on in_valid. out_valid
// and the result do not depend on out_ready.
module vecsum_ctrl #(
  parameter int Elements = 4,
  parameter int NBitsIn  = 8,
  parameter int NBitsOut = 24,
  parameter int Chunks   = 4,
  parameter int Latency  = 3
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [Elements-1:0][NBitsIn-1:0]     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [Elements-1:0][NBitsIn-1:0]     tree_in,
  input  logic signed [NBitsOut-1:0]           tree_out,
  output logic signed [NBitsOut-1:0]           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_sat,
  output logic [1:0]                           dbg_state
);

  localparam int CntW = $clog2(Chunks + 1);
  localparam logic [CntW-1:0] ChunksC = CntW'(Chunks);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [Latency-1:0]          tag_q, tag_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic signed [NBitsOut-1:0]  acc_q, acc_d;
  logic                        valid_q, valid_d;
  logic                        accept;
  logic                        tag_exit;
  logic                        others_busy;
  logic signed [NBitsOut-1:0]  acc_sum;
  logic                        clamp;

`ifdef VECSUM_SAT_EN
  localparam logic signed [NBitsOut-1:0] MaxVal = {1'b0, {(NBitsOut-1){1'b1}}};
  localparam logic signed [NBitsOut-1:0] MinVal = {1'b1, {(NBitsOut-1){1'b0}}};
  logic signed [NBitsOut:0]    sum_ext;
  logic                        sat_q, sat_d;
`endif

  // Beat acceptance and the operand path to the adder tree.
  always_comb begin
    in_ready = !rst_in && ((state_q == IDLE) || (state_q == FEED));
    accept   = in_valid && in_ready;
    tree_in  = accept ? in_data : '0;
  end

  // Tag pipeline: a 1 marks the cycle in which tree_out holds a real beat sum.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = accept;
    for (int i = 1; i < Latency; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_exit    = tag_q[Latency-1];
    others_busy = 1'b0;
    for (int i = 0; i < Latency - 1; i++) begin
      others_busy = others_busy | tag_q[i];
    end
  end

  // One accumulation step, either wrapping or clamping to the signed range.
  always_comb begin
`ifdef VECSUM_SAT_EN
    sum_ext = {acc_q[NBitsOut-1], acc_q} + {tree_out[NBitsOut-1], tree_out};
    clamp   = sum_ext[NBitsOut] ^ sum_ext[NBitsOut-1];
    if (clamp) begin
      acc_sum = sum_ext[NBitsOut] ? MinVal : MaxVal;
    end else begin
      acc_sum = sum_ext[NBitsOut-1:0];
    end
`else
    clamp   = 1'b0;
    acc_sum = acc_q + tree_out;
`endif
  end

  // Next-state logic for the FSM, beat counter, accumulator and result flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = valid_q;
`ifdef VECSUM_SAT_EN
    sat_d   = sat_q;
`endif
    if (tag_exit) begin
      acc_d = acc_sum;
`ifdef VECSUM_SAT_EN
      sat_d = sat_q | clamp;
`endif
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = '0;
          cnt_d = CntW'(1);
`ifdef VECSUM_SAT_EN
          sat_d = 1'b0;
`endif
          state_d = (Chunks == 1) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == ChunksC) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last tag leaving means its sum is folded in at this same edge.
        if (tag_exit && !others_busy) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state registers; the async reset also drops every in-flight tag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      tag_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
`ifdef VECSUM_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
`ifdef VECSUM_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  // Result outputs come straight from registers and only change outside HOLD.
  always_comb begin
    out_data  = acc_q;
    out_valid = valid_q;
    dbg_state = state_q;
`ifdef VECSUM_SAT_EN
    out_sat   = sat_q;
`else
    out_sat   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vecsum_ctrl.sv
// Bench for vecsum_ctrl: three instances (default, 10-bit result, one chunk),
// each fed by a latency-3 adder-tree model. The default instance is
// checked every cycle against a beat-counting reference model.
`timescale 1ns/1ps
module tb_vecsum_ctrl;
  localparam int NO  = 24;
  localparam int CH  = 4;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- instance a: default parameters ----------------
  logic [3:0][7:0]    a_in_data, a_tree_in;
  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic signed [23:0] a_tree_out, a_out_data, a_p0, a_p1, a_p2;
  logic [1:0]         a_state;

  vecsum_ctrl u_dut (
    .clk_in(clk), .rst_in(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .tree_in(a_tree_in), .tree_out(a_tree_out),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sat(a_out_sat), .dbg_state(a_state)
  );

  // ---------------- instance b: 10-bit result ----------------
  logic [3:0][7:0]    b_in_data, b_tree_in;
  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic signed [9:0]  b_tree_out, b_out_data, b_p0, b_p1, b_p2;
  logic [1:0]         b_state;

  vecsum_ctrl #(.NBitsOut(10)) u_dut10 (
    .clk_in(clk), .rst_in(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .tree_in(b_tree_in), .tree_out(b_tree_out),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sat(b_out_sat), .dbg_state(b_state)
  );

  // ---------------- instance c: one chunk per vector ----------------
  logic [3:0][7:0]    c_in_data, c_tree_in;
  logic               c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_sat;
  logic signed [23:0] c_tree_out, c_out_data, c_p0, c_p1, c_p2;
  logic [1:0]         c_state;

  vecsum_ctrl #(.Chunks(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .tree_in(c_tree_in), .tree_out(c_tree_out),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sat(c_out_sat), .dbg_state(c_state)
  );

  function automatic int lane_sum(input logic [3:0][7:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(v[i]));
    return s;
  endfunction

  // External adder trees: three register stages, never reset.
  always @(posedge clk) begin
    a_p0 <= 24'(lane_sum(a_tree_in)); a_p1 <= a_p0; a_p2 <= a_p1;
    b_p0 <= 10'(lane_sum(b_tree_in)); b_p1 <= b_p0; b_p2 <= b_p1;
    c_p0 <= 24'(lane_sum(c_tree_in)); c_p1 <= c_p0; c_p2 <= c_p1;
  end
  assign a_tree_out = a_p2;
  assign b_tree_out = b_p2;
  assign c_tree_out = c_p2;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model for instance a ----------------
  int  m_beats, m_sum, m_left;
  bit  m_full;
  logic [NO-1:0] exp_q[$];

  initial begin : compare
    bit rdy_e, vld_e;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_beats = 0; m_sum = 0; m_left = 0; m_full = 0;
        exp_q.delete();
      end else begin
        if (m_full && m_left > 0) m_left--;
        rdy_e = !m_full;
        vld_e = m_full && (m_left == 0);
        check("mdl_in_ready", a_in_ready, rdy_e);
        check("mdl_out_valid", a_out_valid, vld_e);
        check("mdl_tree_in", a_tree_in, (a_in_valid && rdy_e) ? a_in_data : 32'd0);
        if (vld_e) begin
          check("mdl_out_data", $signed(a_out_data), m_sum);
          check("mdl_out_sat", a_out_sat, 0);
        end
        if (a_in_valid && rdy_e) begin
          m_sum += lane_sum(a_in_data);
          m_beats++;
          if (m_beats == CH) begin
            m_full = 1;
            m_left = LAT + 1;
            exp_q.push_back(NO'(m_sum));
          end
        end
        if (vld_e && a_out_ready) begin
          check("sb_result", $signed(a_out_data), $signed(exp_q.pop_front()));
          m_full = 0; m_beats = 0; m_sum = 0;
        end
      end
    end
  end

  // ---------------- driver tasks (aligned 1ns after a rising edge) ----------------
  function automatic logic [3:0][7:0] seq_beat(input int k);
    logic [3:0][7:0] d;
    for (int i = 0; i < 4; i++) d[i] = 8'(4 * k + i + 1);
    return d;
  endfunction

  task automatic send_beat(input logic [3:0][7:0] d, input int bubbles);
    int  n;
    logic got;
    a_in_valid = 1'b0;
    repeat (bubbles) begin
      a_in_data = $urandom;
      @(posedge clk); #1;
    end
    a_in_data  = d;
    a_in_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk); got = a_in_ready;
      @(posedge clk); #1;
      n++;
    end
    a_in_valid = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(output logic signed [63:0] data, output int ncyc);
    ncyc = 0;
    do begin
      @(negedge clk); ncyc++;
    end while (!a_out_valid && ncyc < 40);
    if (!a_out_valid) check("wait_valid_timeout", 0, 1);
    data = $signed(a_out_data);
  endtask

  task automatic async_pulse();
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_tree_in", a_tree_in, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", $signed(a_out_data), 0);
    check("rst_out_sat", a_out_sat, 0);
    check("rst_state_idle", a_state, 0);
    #4 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic signed [63:0] res;
    int ncyc, n, cnt;
    logic done;
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'hdeadbeef; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
    #2;
    check("reset_in_ready", a_in_ready, 0);
    check("reset_tree_in", a_tree_in, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_data", $signed(a_out_data), 0);
    check("reset_out_sat", a_out_sat, 0);
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", a_in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back 1..16.
    for (int k = 0; k < 4; k++) send_beat(seq_beat(k), 0);
    wait_valid(res, ncyc);
    check("b2b_data", res, 136);
    check("b2b_latency", ncyc, 4);
    check("b2b_in_ready_hold", a_in_ready, 0);
    @(negedge clk);
    check("b2b_in_ready_back", a_in_ready, 1);
    @(posedge clk); #1;

    // Same vector with two-cycle bubbles.
    for (int k = 0; k < 4; k++) send_beat(seq_beat(k), 2);
    wait_valid(res, ncyc);
    check("bubble_data", res, 136);
    check("bubble_latency", ncyc, 4);
    @(posedge clk); #1;

    // All -128, result held while out_ready is low, then reset out of HOLD.
    a_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat({4{8'h80}}, 0);
    a_in_valid = 1'b1; a_in_data = {4{8'h80}};
    wait_valid(res, ncyc);
    check("neg_latency", ncyc, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("neg_hold_data", $signed(a_out_data), -2048);
      check("neg_hold_valid", a_out_valid, 1);
      check("neg_hold_in_ready", a_in_ready, 0);
    end
    async_pulse();
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;

    // Reset mid-vector: stale tree sums must not leak into the next vector.
    send_beat({4{8'd50}}, 0);
    send_beat({4{8'd60}}, 0);
    a_in_valid = 1'b1; a_in_data = {4{8'd99}};
    async_pulse();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send_beat(seq_beat(k), 0);
    wait_valid(res, ncyc);
    check("midrst_data", res, 136);
    @(posedge clk); #1;

    // Randomized vectors, bubbles and back-pressure.
    for (int v = 0; v < 25; v++) begin
      for (int k = 0; k < 4; k++) begin
        a_out_ready = 1'($urandom_range(0, 1));
        send_beat($urandom, $urandom_range(0, 2));
      end
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
        a_out_ready = 1'($urandom_range(0, 1));
        @(negedge clk); done = a_out_valid && a_out_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!done) check("rand_handshake_timeout", 0, 1);
    end
    a_out_ready = 1'b1;

    // 10-bit result: true sum 2032.
    b_in_data = {4{8'd127}}; b_in_valid = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 4 && n < 40) begin
      @(negedge clk); if (b_in_ready) cnt++;
      @(posedge clk); #1;
      n++;
    end
    b_in_valid = 1'b0;
    check("w10_beats", cnt, 4);
    ncyc = 0;
    do begin @(negedge clk); ncyc++; end while (!b_out_valid && ncyc < 40);
    check("w10_valid", b_out_valid, 1);
`ifdef VECSUM_SAT_EN
    check("w10_data", $signed(b_out_data), 511);
    check("w10_sat", b_out_sat, 1);
`else
    check("w10_data", $signed(b_out_data), -16);
    check("w10_sat", b_out_sat, 0);
`endif
    @(posedge clk); #1;

    // One chunk per vector: 1+2+3+4.
    c_in_data = {8'd4, 8'd3, 8'd2, 8'd1}; c_in_valid = 1'b1;
    @(negedge clk);
    check("c1_in_ready", c_in_ready, 1);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    check("c1_state_drain", c_state, 2);
    ncyc = 0;
    do begin @(negedge clk); ncyc++; end while (!c_out_valid && ncyc < 40);
    check("c1_latency", ncyc, 4);
    check("c1_data", $signed(c_out_data), 10);
    @(negedge clk);
    check("c1_in_ready_back", c_in_ready, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vecsum_ctrl.md
VECSUM_CTRL -- requirements
Module: vecsum_ctrl

Interface
REQ-001 SHALL have parameter Elements, default 4: operands per chunk, equal to the tree width.
REQ-002 SHALL have parameter NBitsIn, default 8: signed operand width.
REQ-003 SHALL have parameter NBitsOut, default 24: signed tree-result and accumulator width.
REQ-004 SHALL have parameter Chunks, default 4 (≥1): chunks per vector.
REQ-005 SHALL have parameter Latency, default 3 (≥1): clock cycles from a value on tree_in to its sum on tree_out.
REQ-006 SHALL have port clk_in, input, 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_in, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_data, input, [Elements][NBitsIn]: chunk operands.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1): chunk handshake.
REQ-010 SHALL have port tree_in, output, [Elements][NBitsIn]: operands driven to the external pipelined adder tree.
REQ-011 SHALL have port tree_out, input, NBitsOut: signed tree sum.
REQ-012 SHALL have port out_data, output, NBitsOut: signed vector sum.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-014 SHALL have port out_sat, output, 1: the current result saturated.

Function
REQ-015 SHALL implement FSM states IDLE, FEED, DRAIN and HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and FEED, and 0 in DRAIN and HOLD.
REQ-017 A beat SHALL be accepted in any cycle where in_valid && in_ready.
REQ-018 tree_in SHALL equal in_data combinationally on an accept cycle and all-zero otherwise.
REQ-019 On each accept, a tag SHALL enter a Latency-deep shift register; non-accept cycles shift in 0, so bubbles are allowed.
REQ-020 When a tag exits, the accumulator SHALL add tree_out at that edge; tree_out is ignored when no tag exits.
REQ-021 An accept in IDLE SHALL load the accumulator with 0 and the beat count with 1, then go to FEED, or to DRAIN when Chunks==1.
REQ-022 In FEED, the accept that brings the beat count to Chunks SHALL go to DRAIN.
REQ-023 DRAIN SHALL go to HOLD on the edge where the last tag exits, including that final accumulation.
REQ-024 Net latency: out_valid SHALL rise Latency+1 cycles after the last beat's accept cycle.
REQ-025 In HOLD, out_valid SHALL be 1 and out_data and out_sat SHALL be held stable until out_valid && out_ready.
REQ-026 On that handshake the FSM SHALL go to IDLE; in_ready rises the next cycle, never in the same cycle.
REQ-027 Without saturation, accumulation SHALL wrap modulo 2^NBitsOut as two's complement.
REQ-028 The beat counter SHALL be $clog2(Chunks+1) bits wide and SHALL never exceed Chunks.

Reset
REQ-029 rst_in SHALL act asynchronously, with no clock edge needed, forcing: state IDLE, all tags 0, beat count 0, accumulator 0, out_data 0, out_valid 0, out_sat 0.
REQ-030 While rst_in is high, in_ready SHALL be 0 and tree_in SHALL be all-zero.
REQ-031 A reset mid-vector SHALL discard all in-flight tree results; stale tree_out values are never accumulated after release.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_in deasserts.

Configuration
REQ-033 With macro VECSUM_SAT_EN defined, each accumulation SHALL clamp to [-2^(NBitsOut-1), 2^(NBitsOut-1)-1].
REQ-034 With VECSUM_SAT_EN defined, out_sat SHALL be set if any clamp occurred in the vector and cleared at the next vector start.
REQ-035 Without VECSUM_SAT_EN, accumulation SHALL wrap per REQ-027 and out_sat SHALL be tied to 0.

Verification
REQ-036 Default parameters, a tree model with Latency 3, operands 1..16 in 4 back-to-back beats, out_ready=1 -> out_data=136; out_valid pulses 4 cycles after the 4th accept; in_ready returns 1 the cycle after.
REQ-037 Same vector with 2-cycle in_valid bubbles between beats -> out_data=136; tags and accumulation count exactly 4 beats.
REQ-038 Operands all -128 in 4 beats, out_ready held 0 for 10 cycles -> out_data=-2048 stable throughout; in_ready=0; no extra accept while in_valid=1.
REQ-039 rst_in pulsed asynchronously between clock edges after beat 2 accepted, then vector 1..16 -> rst effective immediately; result=136, not contaminated by the stale beats.
REQ-040 NBitsOut=10, operands all 127, 4 beats (true sum 2032) -> with VECSUM_SAT_EN: out_data=511, out_sat=1; without: out_data=-16, out_sat=0.
REQ-041 Chunks=1, one beat of 1,2,3,4 -> IDLE goes directly to DRAIN; out_data=10 after Latency+1 cycles.
